crc16_tx_framer: RTL and testbench

CRC16_TX_FRAMER -- requirements
Module: crc16_tx_framer

---
 rtl/crc16_pkg.sv | 23 ++
 rtl/crc16_tx_framer_if.sv | 25 ++
 rtl/crc16_step8.sv | 22 ++
 rtl/crc16_tx_framer.sv | 104 ++++++++++
 tb/tb_crc16_tx_framer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/crc16_pkg.sv
// Shared types and constants for the CRC-16/CMS transmit framer.
package crc16_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CRC_W  = 16;

  localparam logic [CRC_W-1:0] CRC16_POLY         = 16'h8005;
  localparam logic [CRC_W-1:0] CRC16_INIT_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CRC_HI = 2'd2,
    CRC_LO = 2'd3
  } state_t;

  // One output beat as held in the output register
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/crc16_tx_framer_if.sv
// Upstream payload stream and downstream framed stream of the CRC-16 framer.
interface crc16_tx_framer_if;

  logic [crc16_pkg::DATA_W-1:0] s_data;
  logic                         s_valid;
  logic                         s_last;
  logic                         s_ready;
  logic [crc16_pkg::DATA_W-1:0] m_data;
  logic                         m_valid;
  logic                         m_last;
  logic                         m_ready;

  // Framer side
  modport master (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  // Environment side: byte source and framed-byte sink
  modport slave (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

endinterface

// File: rtl/crc16_step8.sv
// Combinational CRC-16 (poly 0x8005) update by one byte, MSB first, no reflection.
module crc16_step8
  import crc16_pkg::*;
(
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_next
);

  logic [CRC_W-1:0] acc;

  // Fold the byte into the top of the register, then shift out eight bits
  always_comb begin
    acc = crc_in ^ {data, 8'h00};
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (acc[CRC_W-1]) acc = CRC_W'(acc << 1) ^ CRC16_POLY;
      else              acc = CRC_W'(acc << 1);
    end
    crc_next = acc;
  end

endmodule

// File: rtl/crc16_tx_framer.sv
// Appends a CRC-16/CMS trailer (high byte then low byte) to each payload packet.
// Build option: define CRC16_TX_INVERT_EN to complement the emitted CRC bytes.
module crc16_tx_framer
  import crc16_pkg::*;
#(
  parameter logic [CRC_W-1:0] CRC_INIT = CRC16_INIT_DEFAULT
)(
  input  logic               clk,
  input  logic               rst,
  crc16_tx_framer_if.master  bus,
  output logic [CRC_W-1:0]   crc_out,
  output logic               busy
);

`ifdef CRC16_TX_INVERT_EN
  localparam logic [DATA_W-1:0] CRC_XOR = 8'hFF;
`else
  localparam logic [DATA_W-1:0] CRC_XOR = 8'h00;
`endif

  state_t           state_q, state_d;
  beat_t            out_q, out_d;
  logic             valid_q, valid_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] crc_step_c;
  logic             slot_free_c;
  logic             s_ready_c;
  logic             accept_c;

  crc16_step8 u_step (
    .crc_in   (crc_q),
    .data     (bus.s_data),
    .crc_next (crc_step_c)
  );

  assign slot_free_c = !valid_q || bus.m_ready;
  assign s_ready_c   = !rst && slot_free_c && (state_q == IDLE || state_q == DATA);
  assign accept_c    = bus.s_valid && s_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      crc_q   <= CRC_INIT;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      crc_q   <= crc_d;
    end
  end

  // Next state and output-register load; a free slot with nothing new to load empties it
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = valid_q;
    crc_d   = crc_q;

    if (slot_free_c) begin
      valid_d    = 1'b0;
      out_d.last = 1'b0;
    end

    case (state_q)
      IDLE, DATA: begin
        if (accept_c) begin
          out_d.data = bus.s_data;
          out_d.last = 1'b0;
          valid_d    = 1'b1;
          crc_d      = crc_step_c;
          state_d    = bus.s_last ? CRC_HI : DATA;
        end
      end
      CRC_HI: begin
        if (slot_free_c) begin
          out_d.data = crc_q[15:8] ^ CRC_XOR;
          out_d.last = 1'b0;
          valid_d    = 1'b1;
          state_d    = CRC_LO;
        end
      end
      CRC_LO: begin
        if (slot_free_c) begin
          out_d.data = crc_q[7:0] ^ CRC_XOR;
          out_d.last = 1'b1;
          valid_d    = 1'b1;
          crc_d      = CRC_INIT;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_data  = out_q.data;
  assign bus.m_last  = out_q.last;
  assign bus.m_valid = valid_q;
  assign crc_out     = crc_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_crc16_tx_framer.sv
// Self-checking bench for crc16_tx_framer: packet table plus back-to-back and mid-packet reset sequences.
module tb_crc16_tx_framer;

`ifdef CRC16_TX_INVERT_EN
  localparam logic [7:0] CRC_MASK = 8'hFF;
`else
  localparam logic [7:0] CRC_MASK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] crc_out;
  logic        busy;

  crc16_tx_framer_if bus ();

  crc16_tx_framer #(.CRC_INIT(16'hFFFF)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .crc_out (crc_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          len;
    logic [7:0]  b [9];
    bit          toggle;
    logic [15:0] crc;
  } vec_t;

  vec_t vecs [5];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pkt_d [$];
  logic       pkt_l [$];
  logic [7:0] rx_d  [$];
  logic       rx_l  [$];
  int         stall_cnt, first_acc, first_beat, done_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      if (r[15] ^ d[k]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Drive pkt_d/pkt_l upstream and collect downstream beats until every packet's last beat arrives
  task automatic send(input bit toggle, input int budget);
    int   i = 0;
    int   n = 0;
    int   lasts = 0;
    int   got = 0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic prev_l = 1'b0;
    foreach (pkt_l[k]) if (pkt_l[k]) lasts++;
    rx_d.delete(); rx_l.delete();
    stall_cnt = 0; first_acc = -1; first_beat = -1; done_cyc = -1;
    while (got < lasts && n < budget) begin
      bus.m_ready = toggle ? (n % 2 == 0) : 1'b1;
      bus.s_valid = (i < pkt_d.size());
      bus.s_data  = (i < pkt_d.size()) ? pkt_d[i] : 8'h00;
      bus.s_last  = (i < pkt_d.size()) ? pkt_l[i] : 1'b0;
      #1;
      if (prev_stall) begin
        check("hold_valid", 32'(bus.m_valid), 32'd1);
        check("hold_data",  32'(bus.m_data),  32'(prev_d));
        check("hold_last",  32'(bus.m_last),  32'(prev_l));
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_d     = bus.m_data;
      prev_l     = bus.m_last;
      if (bus.s_valid && !bus.s_ready) stall_cnt++;
      if (bus.s_valid && bus.s_ready) begin
        if (first_acc < 0) first_acc = n;
        i++;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (first_beat < 0) first_beat = n;
        rx_d.push_back(bus.m_data);
        rx_l.push_back(bus.m_last);
        if (bus.m_last) begin
          got++;
          done_cyc = n;
        end
      end
      @(negedge clk);
      n++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    check("packet_complete", 32'(got == lasts), 32'd1);
  endtask

  // Compare collected beats against the payload followed by per-packet model CRC bytes
  task automatic compare_rx(input string tag);
    logic [7:0]  ed [$];
    logic        el [$];
    logic [15:0] c = 16'hFFFF;
    foreach (pkt_d[k]) begin
      ed.push_back(pkt_d[k]);
      el.push_back(1'b0);
      c = model_step(c, pkt_d[k]);
      if (pkt_l[k]) begin
        ed.push_back(c[15:8] ^ CRC_MASK); el.push_back(1'b0);
        ed.push_back(c[7:0] ^ CRC_MASK);  el.push_back(1'b1);
        c = 16'hFFFF;
      end
    end
    check($sformatf("%s_beats", tag), 32'(rx_d.size()), 32'(ed.size()));
    for (int k = 0; k < ed.size() && k < rx_d.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), 32'(rx_d[k]), 32'(ed[k]));
      check($sformatf("%s_last%0d", tag, k), 32'(rx_l[k]), 32'(el[k]));
    end
  endtask

  task automatic run_vec(input int v);
    int len;
    len = vecs[v].len;
    pkt_d.delete(); pkt_l.delete();
    for (int k = 0; k < len; k++) begin
      pkt_d.push_back(vecs[v].b[k]);
      pkt_l.push_back(k == len - 1);
    end
    send(vecs[v].toggle, 200);
    compare_rx(vecs[v].name);
    if (rx_d.size() == len + 2) begin
      check({vecs[v].name, "_crc_hi"}, 32'(rx_d[len]),     32'(vecs[v].crc[15:8] ^ CRC_MASK));
      check({vecs[v].name, "_crc_lo"}, 32'(rx_d[len + 1]), 32'(vecs[v].crc[7:0] ^ CRC_MASK));
    end
    if (!vecs[v].toggle) begin
      check({vecs[v].name, "_latency"}, 32'(first_beat - first_acc), 32'd1);
      check({vecs[v].name, "_done_cyc"}, 32'(done_cyc), 32'(len + 2));
    end
    #1;
    check({vecs[v].name, "_valid_clear"}, 32'(bus.m_valid), 32'd0);
    check({vecs[v].name, "_crc_reinit"}, 32'(crc_out), 32'hFFFF);
    check({vecs[v].name, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{name: "seq9",   len: 9, b: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}, toggle: 1'b0, crc: 16'hAEE7};
    vecs[1] = '{name: "seq9_t", len: 9, b: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}, toggle: 1'b1, crc: 16'hAEE7};
    vecs[2] = '{name: "zero1",  len: 1, b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, toggle: 1'b0, crc: 16'hFD02};
    vecs[3] = '{name: "a5_t",   len: 1, b: '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, toggle: 1'b1, crc: 16'hFEDC};
    vecs[4] = '{name: "two",    len: 2, b: '{8'h31, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, toggle: 1'b0,
                crc: model_step(model_step(16'hFFFF, 8'h31), 8'h32)};

    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_last",  32'(bus.m_last),  32'd0);
    check("rst_m_data",  32'(bus.m_data),  32'd0);
    check("rst_crc",     32'(crc_out),     32'hFFFF);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_vec(v);

    // Back-to-back "12" then "34" with no idle gap on the upstream side
    pkt_d = '{8'h31, 8'h32, 8'h33, 8'h34};
    pkt_l = '{1'b0, 1'b1, 1'b0, 1'b1};
    send(1'b0, 200);
    compare_rx("b2b");
    check("b2b_ready_gap", 32'(stall_cnt), 32'd2);
    @(negedge clk);

    // Reset after four bytes of a nine-byte packet
    for (int k = 0; k < 4; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(8'h31 + k);
      bus.s_last  = 1'b0;
      #1;
      check("mid_accept", 32'(bus.s_ready), 32'd1);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_m_data",  32'(bus.m_data),  32'd0);
    check("mid_rst_busy",    32'(busy),        32'd0);
    check("mid_rst_crc",     32'(crc_out),     32'hFFFF);
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mid_no_crc_beat", 32'(bus.m_valid), 32'd0);
      check("mid_s_ready", 32'(bus.s_ready), 32'd1);
      @(negedge clk);
    end
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected to end earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
